// File: rtl/alu_share_arbiter.sv
// Two-port round-robin arbiter and sequencer for a shared combinational ALU.
// Accepts one request in IDLE, drives the ALU for one cycle, then holds the response until consumed.
module alu_share_arbiter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            req_valid_i,
    output logic [1:0]            req_ready_o,
    input  logic [2*DATA_W-1:0]   req_src1_i,
    input  logic [2*DATA_W-1:0]   req_src2_i,
    input  logic [7:0]            req_ctrl_i,
    output logic [1:0]            rsp_valid_o,
    input  logic [1:0]            rsp_ready_i,
    output logic [DATA_W-1:0]     rsp_result_o,
    output logic                  rsp_zero_o,
    output logic                  rsp_err_o,
    output logic [DATA_W-1:0]     alu_src1_o,
    output logic [DATA_W-1:0]     alu_src2_o,
    output logic [3:0]            alu_ctrl_o,
    input  logic [DATA_W-1:0]     alu_result_i,
    input  logic                  alu_zero_i,
    output logic                  busy_o
);

    localparam int unsigned CTRL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic                accept;
    logic                grant_any;
    logic                grant_port;
    logic                last_grant;
    logic                grant_id;
    logic [DATA_W-1:0]   op_src1;
    logic [DATA_W-1:0]   op_src2;
    logic [CTRL_W-1:0]   op_ctrl;
    logic [DATA_W-1:0]   rsp_result;
    logic                rsp_zero;
    logic                rsp_err;
    logic [1:0]          rsp_valid;
    logic                busy;

    function automatic logic op_supported(input logic [CTRL_W-1:0] ctrl);
        case (ctrl)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: op_supported = 1'b1;
            default:                                              op_supported = 1'b0;
        endcase
    endfunction

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        grant_any  = |req_valid_i;
        grant_port = (&req_valid_i) ? ~last_grant : req_valid_i[1];
    end

    // Next-state and combinational request-ready decode.
    always_comb begin
        next_state  = state;
        req_ready_o = 2'b00;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any && !rst_i) begin
                    req_ready_o[grant_port] = 1'b1;
                    accept                  = 1'b1;
                    next_state              = EXEC;
                end
            end
            EXEC: next_state = RESP;
            RESP: begin
                if (rsp_ready_i[grant_id]) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register; busy and rsp_valid are registered from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rsp_valid <= 2'b00;
        end else begin
            state     <= next_state;
            busy      <= (next_state != IDLE);
            rsp_valid <= (next_state == RESP) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
        end
    end

    // Operand latch on handshake, response capture in EXEC.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            op_src1    <= '0;
            op_src2    <= '0;
            op_ctrl    <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant_port;
                grant_id   <= grant_port;
                op_src1    <= grant_port ? req_src1_i[2*DATA_W-1:DATA_W] : req_src1_i[DATA_W-1:0];
                op_src2    <= grant_port ? req_src2_i[2*DATA_W-1:DATA_W] : req_src2_i[DATA_W-1:0];
                op_ctrl    <= grant_port ? req_ctrl_i[7:4] : req_ctrl_i[3:0];
            end
            if (state == EXEC) begin
                rsp_result <= alu_result_i;
                rsp_zero   <= alu_zero_i;
                rsp_err    <= ~op_supported(op_ctrl);
            end
        end
    end

    assign alu_src1_o   = op_src1;
    assign alu_src2_o   = op_src2;
    assign alu_ctrl_o   = op_ctrl;
    assign rsp_result_o = rsp_result;
    assign rsp_zero_o   = rsp_zero;
    assign rsp_err_o    = rsp_err;
    assign rsp_valid_o  = rsp_valid;
    assign busy_o       = busy;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized self-checking bench for alu_share_arbiter with a transaction-level reference model
// and a behavioural stand-in for the shared ALU.
module tb_alu_share_arbiter;

    localparam int unsigned DATA_W = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*DATA_W-1:0] req_src1;
    logic [2*DATA_W-1:0] req_src2;
    logic [7:0]          req_ctrl;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [DATA_W-1:0]   rsp_result;
    logic                rsp_zero;
    logic                rsp_err;
    logic [DATA_W-1:0]   alu_src1;
    logic [DATA_W-1:0]   alu_src2;
    logic [3:0]          alu_ctrl;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_zero;
    logic                busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic m_last;
    logic obs_grant;

    alu_share_arbiter #(.DATA_W(DATA_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_src1_i(req_src1), .req_src2_i(req_src2), .req_ctrl_i(req_ctrl),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero), .rsp_err_o(rsp_err),
        .alu_src1_o(alu_src1), .alu_src2_o(alu_src2), .alu_ctrl_o(alu_ctrl),
        .alu_result_i(alu_result), .alu_zero_i(alu_zero),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return (a < b) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit is_supported(input logic [3:0] c);
        return c inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    endfunction

    // Shared ALU stand-in.
    assign alu_result = alu_ref(alu_ctrl, alu_src1, alu_src2);
    assign alu_zero   = (alu_result == 32'd0);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One full transaction from IDLE back to IDLE; starts and ends at a negedge.
    task automatic do_op(input logic [1:0] v, input logic [3:0] c0, input logic [3:0] c1,
                         input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1,
                         input int stall, input bit wrong);
        logic g;
        logic [31:0] ea, eb, er;
        logic [3:0]  ec;
        logic [1:0]  oh;
        g  = (v == 2'b11) ? ~m_last : v[1];
        ea = g ? a1 : a0;
        eb = g ? b1 : b0;
        ec = g ? c1 : c0;
        er = alu_ref(ec, ea, eb);
        oh = g ? 2'b10 : 2'b01;
        req_valid = v;
        req_src1  = {a1, a0};
        req_src2  = {b1, b0};
        req_ctrl  = {c1, c0};
        rsp_ready = 2'b00;
        #1;
        check("idle_busy", 64'(busy), 64'(0));
        check("req_ready_grant", 64'(req_ready), 64'(oh));
        obs_grant = req_ready[1];
        @(posedge clk);
        m_last = g;
        @(negedge clk);
        req_src1 = {$urandom, $urandom};
        req_src2 = {$urandom, $urandom};
        req_ctrl = 8'($urandom);
        check("exec_req_ready", 64'(req_ready), 64'(0));
        check("exec_busy", 64'(busy), 64'(1));
        check("exec_rsp_valid", 64'(rsp_valid), 64'(0));
        check("alu_src1", 64'(alu_src1), 64'(ea));
        check("alu_src2", 64'(alu_src2), 64'(eb));
        check("alu_ctrl", 64'(alu_ctrl), 64'(ec));
        @(posedge clk);
        @(negedge clk);
        check("rsp_valid", 64'(rsp_valid), 64'(oh));
        check("rsp_result", 64'(rsp_result), 64'(er));
        check("rsp_zero", 64'(rsp_zero), 64'(er == 32'd0));
        check("rsp_err", 64'(rsp_err), 64'(!is_supported(ec)));
        for (int k = 0; k < stall; k++) begin
            rsp_ready = wrong ? ~oh : 2'b00;
            @(posedge clk);
            @(negedge clk);
            check("stall_rsp_valid", 64'(rsp_valid), 64'(oh));
            check("stall_result", 64'(rsp_result), 64'(er));
            check("stall_err", 64'(rsp_err), 64'(!is_supported(ec)));
            check("stall_req_ready", 64'(req_ready), 64'(0));
            check("stall_busy", 64'(busy), 64'(1));
            check("stall_alu_src1", 64'(alu_src1), 64'(ea));
        end
        rsp_ready = oh;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 2'b00;
        check("release_busy", 64'(busy), 64'(0));
        check("release_rsp_valid", 64'(rsp_valid), 64'(0));
        req_valid = 2'b00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] ops [8];
        ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0110;
        ops[4] = 4'b0111; ops[5] = 4'b1100; ops[6] = 4'b1111; ops[7] = 4'b0011;
        rst = 1'b1;
        req_valid = 2'b01;
        req_src1 = '0; req_src2 = '0; req_ctrl = '0; rsp_ready = 2'b00;
        m_last = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_result", 64'(rsp_result), 64'(0));
        check("rst_zero", 64'(rsp_zero), 64'(0));
        check("rst_err", 64'(rsp_err), 64'(0));
        check("rst_alu", 64'({alu_src1, alu_src2} ^ 64'(alu_ctrl)), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        req_valid = 2'b00;
        rst = 1'b0;
        @(negedge clk);

        // Contention from reset: grants alternate starting at port 0.
        for (int i = 0; i < 4; i++) begin
            do_op(2'b11, 4'b0010, 4'b0001, $urandom, $urandom, $urandom, $urandom, 0, 1'b0);
            check("rr_order", 64'(obs_grant), 64'(i % 2));
        end

        do_op(2'b01, 4'b0010, 4'b0000, 32'd5, 32'd7, 32'd0, 32'd0, 0, 1'b0);
        check("add_result", 64'(rsp_result), 64'(12));
        do_op(2'b10, 4'b0000, 4'b0110, 32'd0, 32'd0, 32'd3, 32'd3, 0, 1'b0);
        check("sub_zero_result", 64'(rsp_result), 64'(0));
        do_op(2'b10, 4'b0000, 4'b0110, 32'd0, 32'd0, 32'd0, 32'd1, 0, 1'b0);
        check("sub_wrap_result", 64'(rsp_result), 64'(32'hFFFF_FFFF));
        do_op(2'b01, 4'b0010, 4'b0000, 32'd100, 32'd23, 32'd0, 32'd0, 5, 1'b1);
        do_op(2'b01, 4'b1111, 4'b0000, 32'd9, 32'd4, 32'd0, 32'd0, 0, 1'b0);
        check("unsup_err", 64'(rsp_err), 64'(1));
        check("unsup_zero", 64'(rsp_zero), 64'(1));
        do_op(2'b01, 4'b0111, 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 0, 1'b0);
        check("slt_unsigned", 64'(rsp_result), 64'(0));

        // Reset while in EXEC drops the operation.
        req_valid = 2'b10;
        req_src1  = {32'd1, 32'd0};
        req_src2  = {32'd1, 32'd0};
        req_ctrl  = 8'h20;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        check("pre_rst_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_alu_src1", 64'(alu_src1), 64'(0));
        rst = 1'b0;
        m_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        do_op(2'b11, 4'b0001, 4'b0001, 32'd1, 32'd2, 32'd3, 32'd4, 0, 1'b0);
        check("post_rst_tie", 64'(obs_grant), 64'(0));

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a0, b0, a1, b1;
            a0 = ($urandom % 4 == 0) ? 32'($urandom % 4) : $urandom;
            b0 = ($urandom % 4 == 0) ? 32'($urandom % 4) : $urandom;
            a1 = ($urandom % 4 == 0) ? 32'($urandom % 4) : $urandom;
            b1 = ($urandom % 4 == 0) ? 32'($urandom % 4) : $urandom;
            do_op(2'($urandom_range(1, 3)), ops[$urandom % 8], ops[$urandom % 8],
                  a0, b0, a1, b1, int'($urandom_range(0, 3)), 1'($urandom % 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
